// File: rtl/vga_scan_ctrl.sv
// -----------------------------------------------------------------------------
// vga_scan_ctrl
//
// VGA 640x480@60 scan generator and pixel colouriser for the snake display.
// A divide-by-2 pixel enable runs the scan counters at 25 MHz from the
// 50 MHz system clock. The playfield logic sees the scan position on
// x_pos/y_pos and returns a 2-bit pixel class on `snake` for that position.
// This block then registers sync and colour together, so they stay aligned.
//
// Optional feature macro: VGA_GRID_EN
//   Defined   : active "none" pixels on a 16-pixel cell boundary
//               (x_pos[3:0]==0 or y_pos[3:0]==0) are drawn blue (001).
//   Undefined : no grid; "none" pixels are black.
//
// Ports
//   CLK_50M      in   1   system clock, 50 MHz
//   RST          in   1   synchronous reset, active-high
//   x_pos        out  10  horizontal scan count, 0..H_TOTAL-1
//   y_pos        out  10  vertical scan count, 0..V_TOTAL-1
//   snake        in   2   pixel class at x_pos/y_pos: 00 none, 01 head,
//                         10 body, 11 wall
//   apple_x      in   6   apple cell column (16-pixel cells)
//   apple_y      in   6   apple cell row
//   apple_en     in   1   apple visible
//   hsync        out  1   horizontal sync, active-low
//   vsync        out  1   vertical sync, active-low
//   rgb          out  3   {R,G,B} pixel colour
//   frame_start  out  1   one-clock pulse at the start of each frame
//
// Both H_TOTAL and V_TOTAL must be <= 1024 so that they fit the 10-bit counters.
// -----------------------------------------------------------------------------
module vga_scan_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       CLK_50M,
  input  logic       RST,
  output logic [9:0] x_pos,
  output logic [9:0] y_pos,
  input  logic [1:0] snake,
  input  logic [5:0] apple_x,
  input  logic [5:0] apple_y,
  input  logic       apple_en,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic       pix_en;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       h_wrap;
  logic       v_wrap;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  // Scan counters. Everything advances only on the pixel-enable cycle.
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      pix_en <= 1'b0;
      h_cnt  <= '0;
      v_cnt  <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        h_cnt <= h_wrap ? '0 : h_cnt + 10'd1;
        if (h_wrap) begin
          v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
        end
      end
    end
  end

  // The counters themselves are the registered scan position.
  assign x_pos = h_cnt;
  assign y_pos = v_cnt;

  // Stage-1 decode of the current scan position and the returned pixel class.
  logic       pix_active;
  logic       hs_next;
  logic       vs_next;
  logic       apple_hit;
  logic [2:0] colour;

  always_comb begin
    pix_active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    hs_next    = !((h_cnt >= HS_START) && (h_cnt <= HS_END));
    vs_next    = !((v_cnt >= VS_START) && (v_cnt <= VS_END));
    apple_hit  = apple_en && (h_cnt[9:4] == apple_x) && (v_cnt[9:4] == apple_y);
    colour     = 3'b000;
    if (pix_active) begin
      // Wall, head and body outrank the apple; the apple outranks the grid.
      case (snake)
        2'b11:   colour = 3'b001;
        2'b01:   colour = 3'b100;
        2'b10:   colour = 3'b010;
        default: begin
          if (apple_hit) begin
            colour = 3'b110;
          end
`ifdef VGA_GRID_EN
          else if ((h_cnt[3:0] == 4'd0) || (v_cnt[3:0] == 4'd0)) begin
            colour = 3'b001;
          end
`endif
        end
      endcase
    end
  end

  // Sync and colour are captured in the same register stage, so they stay
  // aligned one pixel period (2 clocks) behind x_pos/y_pos.
  // frame_start is set one clock early, on the idle half of pixel (0,0). It
  // is therefore high during the enable cycle of that pixel. The counters
  // cannot move on an idle cycle, so that look-ahead is exact.
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      rgb         <= 3'b000;
      frame_start <= 1'b0;
    end else begin
      frame_start <= !pix_en && (h_cnt == 10'd0) && (v_cnt == 10'd0);
      if (pix_en) begin
        hsync <= hs_next;
        vsync <= vs_next;
        rgb   <= colour;
      end
    end
  end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vga_scan_ctrl
//
// Directed bench for vga_scan_ctrl. The horizontal timing uses the real
// 640-pixel line (800 pixels, 1600 clocks per line). The vertical timing is
// shrunk to 12 visible lines + 2 front porch + 2 sync + 2 back porch
// (18 lines, 28800 clocks per frame) so that a whole frame fits a short run.
//
// Timing facts the expectations use. Cycle c0 is the first cycle after reset
// is released.
//   x_pos = k first appears at cycle 2k (k >= 1)
//   rgb/hsync/vsync at cycle t describe the position shown at cycle t-2
//   hsync falls at c1314 (x=657) and rises at c1506; the line period is 1600
//   frame_start is high at c1 and then every 28800 clocks
//   vsync falls at x=1,y=14 and stays low for 2 lines = 3200 clocks
// -----------------------------------------------------------------------------
module tb_vga_scan_ctrl;

  localparam logic [9:0] V_ACT = 10'd12;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic [1:0] snake;
  logic [5:0] apple_x;
  logic [5:0] apple_y;
  logic       apple_en;
  logic       hsync;
  logic       vsync;
  logic [2:0] rgb;
  logic       frame_start;

  always #10 clk = ~clk;

  vga_scan_ctrl #(
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) dut (
    .CLK_50M     (clk),
    .RST         (rst),
    .x_pos       (x_pos),
    .y_pos       (y_pos),
    .snake       (snake),
    .apple_x     (apple_x),
    .apple_y     (apple_y),
    .apple_en    (apple_en),
    .hsync       (hsync),
    .vsync       (vsync),
    .rgb         (rgb),
    .frame_start (frame_start)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int mode   = 0;   // 0 none, 1 head block, 2 body everywhere, 3 wall everywhere
  bit glitch = 1'b1;
  logic [9:0] xh0, xh1, xh2, yh0, yh1, yh2;

  // Playfield stand-in: the pixel class for a scan position.
  function automatic logic [1:0] pf(input logic [9:0] x, input logic [9:0] y);
    case (mode)
      1:       return (x >= 10'd160 && x <= 10'd175 && y >= 10'd2 && y <= 10'd5) ? 2'b01 : 2'b00;
      2:       return 2'b10;
      3:       return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Expected colour of a scan position.
  function automatic logic [2:0] exp_colour(input logic [9:0] x, input logic [9:0] y);
    logic [1:0] c;
    c = pf(x, y);
    if (!(x < 10'd640 && y < V_ACT)) return 3'b000;
    if (c == 2'b11) return 3'b001;
    if (c == 2'b01) return 3'b100;
    if (c == 2'b10) return 3'b010;
    if (apple_en && x[9:4] == apple_x && y[9:4] == apple_y) return 3'b110;
`ifdef VGA_GRID_EN
    if (x[3:0] == 4'd0 || y[3:0] == 4'd0) return 3'b001;
`endif
    return 3'b000;
  endfunction

  // Advance one clock. The bench samples on the falling edge and updates
  // `snake` from the position shown at that moment. On the first cycle of a
  // new position, `snake` is driven with a wrong class. The DUT samples only
  // on the enable cycle, so that wrong value must never be used.
  task automatic step();
    logic [1:0] want;
    @(negedge clk);
    xh2 = xh1; xh1 = xh0; xh0 = x_pos;
    yh2 = yh1; yh1 = yh0; yh0 = y_pos;
    cyc++;
    want  = pf(x_pos, y_pos);
    snake = (glitch && (xh0 !== xh1 || yh0 !== yh1)) ? ~want : want;
  endtask

  task automatic start_history();
    xh0 = x_pos; xh1 = x_pos; xh2 = x_pos;
    yh0 = y_pos; yh1 = y_pos; yh2 = y_pos;
    cyc   = 0;
    snake = pf(x_pos, y_pos);
  endtask

  // Hold reset for n falling edges, then release. The release cycle is c0.
  task automatic apply_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
    start_history();
  endtask

  task automatic test_reset();
    mode = 0; apple_en = 1'b0; apple_x = '0; apple_y = '0; snake = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (x_pos !== 10'd0) begin errors++; $display("FAIL reset_x_pos: got %0d expected 0", x_pos); end
    checks++; if (y_pos !== 10'd0) begin errors++; $display("FAIL reset_y_pos: got %0d expected 0", y_pos); end
    checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b expected 1", hsync); end
    checks++; if (vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b expected 1", vsync); end
    checks++; if (rgb !== 3'b000) begin errors++; $display("FAIL reset_rgb: got %b expected 000", rgb); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
  endtask

  task automatic test_line_timing();
    logic prev_h;
    int nf, nr, vlow;
    int f[2];
    int r[2];
    nf = 0; nr = 0; vlow = 0;
    f = '{-1, -1}; r = '{-1, -1};
    mode = 0; glitch = 1'b1; apple_en = 1'b0;
    apply_reset(2);
    prev_h = hsync;
    repeat (3400) begin
      step();
      if (prev_h && !hsync) begin if (nf < 2) f[nf] = cyc; nf++; end
      if (!prev_h && hsync) begin if (nr < 2) r[nr] = cyc; nr++; end
      if (!vsync) vlow++;
      prev_h = hsync;
    end
    checks++; if (nf !== 2) begin errors++; $display("FAIL line_hsync_falls: got %0d expected 2", nf); end
    checks++; if (nr !== 2) begin errors++; $display("FAIL line_hsync_rises: got %0d expected 2", nr); end
    checks++; if (f[0] !== 1314) begin errors++; $display("FAIL line_hsync_first_fall: got cycle %0d expected 1314", f[0]); end
    checks++; if (f[1] - f[0] !== 1600) begin errors++; $display("FAIL line_period: got %0d expected 1600", f[1] - f[0]); end
    checks++; if (r[0] - f[0] !== 192) begin errors++; $display("FAIL line0_hsync_width: got %0d expected 192", r[0] - f[0]); end
    checks++; if (r[1] - f[1] !== 192) begin errors++; $display("FAIL line1_hsync_width: got %0d expected 192", r[1] - f[1]); end
    checks++; if (vlow !== 0) begin errors++; $display("FAIL line_vsync_low: got %0d expected 0", vlow); end
  endtask

  task automatic test_frame_wall();
    logic prev_v, prev_fs;
    int nfs, vlow, vfall_x, vfall_y, double_fs;
    int fs[2];
    logic [2:0] exp;
    nfs = 0; vlow = 0; vfall_x = -1; vfall_y = -1; double_fs = 0;
    fs = '{-1, -1};
    mode = 3; glitch = 1'b1; apple_en = 1'b0;
    apply_reset(2);
    prev_v = vsync; prev_fs = frame_start;
    repeat (28810) begin
      step();
      if (cyc >= 2) begin
        exp = exp_colour(xh2, yh2);
        checks++;
        if (rgb !== exp) begin
          errors++;
          $display("FAIL wall_rgb x=%0d y=%0d: got %b expected %b", xh2, yh2, rgb, exp);
        end
      end
      if (frame_start) begin if (nfs < 2) fs[nfs] = cyc; nfs++; end
      if (frame_start && prev_fs) double_fs++;
      if (!vsync) vlow++;
      if (prev_v && !vsync) begin vfall_x = x_pos; vfall_y = y_pos; end
      prev_v = vsync; prev_fs = frame_start;
    end
    checks++; if (nfs !== 2) begin errors++; $display("FAIL frame_start_count: got %0d expected 2", nfs); end
    checks++; if (double_fs !== 0) begin errors++; $display("FAIL frame_start_width: got %0d wide pulses expected 0", double_fs); end
    checks++; if (fs[0] !== 1) begin errors++; $display("FAIL frame_start_first: got cycle %0d expected 1", fs[0]); end
    checks++; if (fs[1] - fs[0] !== 28800) begin errors++; $display("FAIL frame_period: got %0d expected 28800", fs[1] - fs[0]); end
    checks++; if (vlow !== 3200) begin errors++; $display("FAIL vsync_width: got %0d expected 3200", vlow); end
    checks++; if (vfall_y !== 14) begin errors++; $display("FAIL vsync_fall_line: got %0d expected 14", vfall_y); end
    checks++; if (vfall_x !== 1) begin errors++; $display("FAIL vsync_fall_x: got %0d expected 1", vfall_x); end
  endtask

  task automatic test_head();
    int head_cnt, guard;
    logic [2:0] exp;
    head_cnt = 0; guard = 0;
    mode = 1; glitch = 1'b1; apple_en = 1'b0;
    apply_reset(2);
    while (!(cyc >= 2 && yh2 == 10'd7) && guard < 15000) begin
      step();
      guard++;
      if (cyc >= 2) begin
        exp = exp_colour(xh2, yh2);
        checks++;
        if (rgb !== exp) begin
          errors++;
          $display("FAIL head_rgb x=%0d y=%0d: got %b expected %b", xh2, yh2, rgb, exp);
        end
        if (rgb === 3'b100) head_cnt++;
      end
    end
    checks++; if (guard >= 15000) begin errors++; $display("FAIL head_timeout: got %0d cycles expected under 15000", guard); end
    checks++; if (head_cnt !== 128) begin errors++; $display("FAIL head_pixel_clocks: got %0d expected 128", head_cnt); end
  endtask

  task automatic test_apple();
    int cfg_mode[4] = '{0, 2, 0, 0};
    bit cfg_en[4]   = '{1, 1, 0, 1};
    int cfg_ay[4]   = '{0, 0, 0, 1};
    int cfg_cnt[4]  = '{64, 0, 0, 0};
    int apple_cnt, guard;
    logic [2:0] exp;
    for (int k = 0; k < 4; k++) begin
      mode = cfg_mode[k]; apple_en = cfg_en[k];
      apple_x = 6'd5; apple_y = 6'(cfg_ay[k]);
      glitch = 1'b1; apple_cnt = 0; guard = 0;
      apply_reset(2);
      while (!(cyc >= 2 && yh2 == 10'd2) && guard < 5000) begin
        step();
        guard++;
        if (cyc >= 2) begin
          exp = exp_colour(xh2, yh2);
          checks++;
          if (rgb !== exp) begin
            errors++;
            $display("FAIL apple_rgb cfg=%0d x=%0d y=%0d: got %b expected %b", k, xh2, yh2, rgb, exp);
          end
          if (rgb === 3'b110) apple_cnt++;
        end
      end
      checks++; if (guard >= 5000) begin errors++; $display("FAIL apple_timeout cfg=%0d: got %0d cycles expected under 5000", k, guard); end
      checks++; if (apple_cnt !== cfg_cnt[k]) begin errors++; $display("FAIL apple_pixel_clocks cfg=%0d: got %0d expected %0d", k, apple_cnt, cfg_cnt[k]); end
    end
  endtask

  task automatic test_reset_mid_line();
    int guard;
    logic prev_h;
    mode = 0; glitch = 1'b0; apple_en = 1'b0;
    apply_reset(2);
    guard = 0;
    while (x_pos !== 10'd700 && guard < 2000) begin step(); guard++; end
    checks++; if (guard >= 2000) begin errors++; $display("FAIL mid_reach_700: got x=%0d expected 700", x_pos); end
    checks++; if (hsync !== 1'b0) begin errors++; $display("FAIL mid_in_sync: got hsync=%b expected 0", hsync); end
    rst = 1'b1;
    step();
    checks++; if (hsync !== 1'b1) begin errors++; $display("FAIL mid_rst_hsync: got %b expected 1", hsync); end
    checks++; if (x_pos !== 10'd0) begin errors++; $display("FAIL mid_rst_x_pos: got %0d expected 0", x_pos); end
    checks++; if (y_pos !== 10'd0) begin errors++; $display("FAIL mid_rst_y_pos: got %0d expected 0", y_pos); end
    checks++; if (rgb !== 3'b000) begin errors++; $display("FAIL mid_rst_rgb: got %b expected 000", rgb); end
    rst = 1'b0;
    start_history();
    step();
    checks++; if (frame_start !== 1'b1) begin errors++; $display("FAIL mid_restart_frame_start: got %b expected 1", frame_start); end
    step();
    checks++; if (x_pos !== 10'd1) begin errors++; $display("FAIL mid_restart_x_pos: got %0d expected 1", x_pos); end
    prev_h = hsync; guard = 0;
    while (!(prev_h && !hsync) && guard < 2000) begin prev_h = hsync; step(); guard++; end
    checks++; if (cyc !== 1314) begin errors++; $display("FAIL mid_restart_hsync_fall: got cycle %0d expected 1314", cyc); end
  endtask

  initial begin
    rst = 1'b1; snake = 2'b00; apple_x = '0; apple_y = '0; apple_en = 1'b0;
    test_reset();
    test_line_timing();
    test_frame_wall();
    test_head();
    test_apple();
    test_reset_mid_line();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_scan_ctrl.md
Name: vga_scan_ctrl

Overview:
VGA 640x480@60 scan generator and pixel colouriser for the snake display path.
- Produces the scan coordinates `x_pos`/`y_pos` that the playfield logic consumes.
- Takes back the 2-bit pixel class returned for those coordinates, plus the apple cell position.
- Drives `hsync`, `vsync` and 3-bit RGB to the connector.
- Runs from the 50 MHz system clock using a divide-by-2 pixel enable.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)

Ports:
- CLK_50M  in  1  system clock, 50 MHz
- RST  in  1  synchronous reset, active-high
- x_pos  out  10  current horizontal scan count, 0..H_TOTAL-1
- y_pos  out  10  current vertical scan count, 0..V_TOTAL-1
- snake  in  2  pixel class for the current `x_pos`/`y_pos`: 00 none, 01 head, 10 body, 11 wall
- apple_x  in  6  apple cell column (16-pixel cells)
- apple_y  in  6  apple cell row
- apple_en  in  1  apple visible
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- rgb  out  3  {R,G,B} pixel colour
- frame_start  out  1  one-clock pulse at the start of each frame

Behaviour:
- Interface: one clock `CLK_50M`; reset `RST` is synchronous and active-high.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525). Both totals must be ≤1024.
- `pix_en`: register toggling every `CLK_50M` cycle, reset 0. All scan and pipeline state updates only on cycles where `pix_en`=1.
- `h_cnt`: increments on `pix_en`; wraps H_TOTAL-1 → 0.
- `v_cnt`: increments only when `h_cnt` wraps; wraps V_TOTAL-1 → 0.
- Outputs `x_pos`=`h_cnt`, `y_pos`=`v_cnt`, both registered. The `snake` input is treated as a combinational function of these.
- Stage 1 (on `pix_en`), captures:
  - `active` = (`h_cnt`<H_ACTIVE && `v_cnt`<V_ACTIVE)
  - `hs` = !(`h_cnt` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]), i.e. low for 656..751
  - `vs` = !(`v_cnt` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]), i.e. low for 490..491
  - `snake` class
  - apple hit = `apple_en` && `x_pos[9:4]`==`apple_x` && `y_pos[9:4]`==`apple_y`
- Stage 1 outputs: `hsync`/`vsync`/`rgb` are registered from stage 1. Sync and colour therefore stay aligned, with a total latency of one pixel period (2 clocks) from `x_pos`/`y_pos` to `rgb`.
- Colour map, in priority order:
  1. not active → 000
  2. wall → 001
  3. head → 100
  4. body → 010
  5. apple → 110
  6. none → 000
- Apple does not override wall, head or body.
- `frame_start`: 1 for exactly one `CLK_50M` cycle, on the cycle where `pix_en`=1 and `h_cnt`=0 and `v_cnt`=0.
- Reset values: `pix_en`=0, `h_cnt`=0, `v_cnt`=0, `x_pos`=0, `y_pos`=0, `hsync`=1, `vsync`=1, `rgb`=000, `frame_start`=0, pipeline cleared.
- Reset asserted mid-line or mid-frame: all of the above are restored on the next clock edge. No partial sync pulse continues after reset.
- Input changes on `snake`/`apple_*` between pixel enables are ignored; only the value present on a `pix_en` cycle is sampled.

Optional Feature:
- Macro: VGA_GRID_EN.
- Defined: a pixel classed none and not apple, inside the active area, with `x_pos[3:0]`==0 or `y_pos[3:0]`==0, is drawn as 001 (cell grid). Wall, head, body and apple take precedence over the grid.
- Undefined: no grid; none pixels are 000. Everything else is identical.

Test Plan:
- Reset, run 2 lines → `hsync` low for exactly 192 clocks per line, line period 1600 clocks, `vsync` stays 1 on lines 0-1.
- Run 1 full frame → `vsync` low for exactly 3200 clocks starting at line 490; `frame_start` pulses every 840000 clocks, width 1 clock.
- Force `snake`=01 only while `x_pos`=160..175, `y_pos`=80..95 → `rgb`=100 for exactly those pixels, delayed 2 clocks; 000 elsewhere in that region.
- `apple_x`=5, `apple_y`=3, `apple_en`=1, `snake`=00 → `rgb`=110 at x 80..95, y 48..63. Same with `snake`=10 → 010 (body wins). `apple_en`=0 → 000.
- `snake`=11 held constant → `rgb`=001 only for x<640, y<480; 000 in all blanking intervals.
- Assert `RST` for 1 clock at `h_cnt`=700 (inside hsync) → next cycle `hsync`=1, `x_pos`=0, `y_pos`=0, `rgb`=000; scan then restarts cleanly from 0.
